// File: rtl/pwm_shadow_update_ctrl_if.sv
// Handshake/bus bundle between the CPU-side controller and the PWM shadow update sequencer.
interface pwm_shadow_update_ctrl_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 16
);
   logic             en;
   logic             carrier_zero;
   logic             carrier_top;
   logic [1:0]       update_mode;
   logic             commit;
   logic [N_CH-1:0]  commit_ch;
   logic [N_CH-1:0]  mask_event;
   logic             pwm_onoff;
   logic [N_CH-1:0]  pending;
   logic             busy;
   logic [CNT_W-1:0] update_count;

   modport master (
      output en, carrier_zero, carrier_top, update_mode, commit, commit_ch,
      input  mask_event, pwm_onoff, pending, busy, update_count
   );

   modport slave (
      input  en, carrier_zero, carrier_top, update_mode, commit, commit_ch,
      output mask_event, pwm_onoff, pending, busy, update_count
   );
endinterface

// File: rtl/pwm_shadow_update_ctrl.sv
// Sequences per-channel shadow-mask transparency pulses on carrier boundaries and owns PWM on/off.
// Optional macro PWM_UPDATE_CNT_EN enables the saturating update_count; otherwise it is tied to 0.
module pwm_shadow_update_ctrl #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = 16
) (
   input logic                     clk,
   input logic                     reset,
   pwm_shadow_update_ctrl_if.slave bus
);
   localparam logic PWM_OFF = 1'b0;
   localparam logic PWM_ON  = 1'b1;

   typedef enum logic [1:0] {S_OFF, S_ARMING, S_ON, S_STOPPING} state_t;

   state_t          r_state;
   logic [N_CH-1:0] r_mask_event;
   logic [N_CH-1:0] r_pending;
   logic            r_pwm_onoff;
   logic            r_busy;
   logic            w_bnd;
   logic            w_fire;
   logic [N_CH-1:0] w_pending_upd;

   // Update boundary selected by update_mode; zero+top together is still one boundary.
   always_comb begin
      w_bnd = 1'b0;
      case (bus.update_mode)
         2'd0:    w_bnd = bus.carrier_zero;
         2'd1:    w_bnd = bus.carrier_top;
         2'd2:    w_bnd = bus.carrier_zero | bus.carrier_top;
         default: w_bnd = 1'b1;
      endcase
   end

   // A commit landing on a firing boundary is held for the next one, never merged.
   assign w_fire        = w_bnd && (r_pending != '0);
   assign w_pending_upd = (w_fire ? '0 : r_pending) | (bus.commit ? bus.commit_ch : '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_OFF;
         r_mask_event <= '0;
         r_pending    <= '0;
         r_pwm_onoff  <= PWM_OFF;
         r_busy       <= 1'b0;
      end else begin
         r_mask_event <= '0;
         case (r_state)
            S_OFF: begin
               r_pending <= '0;
               if (bus.en) begin
                  r_state <= S_ARMING;
                  r_busy  <= 1'b1;
               end
            end
            S_ARMING: begin
               if (!bus.en) begin
                  r_state <= S_OFF;
                  r_busy  <= 1'b0;
               end else if (bus.carrier_zero) begin
                  r_mask_event <= '1;
                  r_pwm_onoff  <= PWM_ON;
                  r_busy       <= 1'b0;
                  r_state      <= S_ON;
               end
            end
            S_ON: begin
               if (w_fire) r_mask_event <= r_pending;
               r_pending <= w_pending_upd;
               if (!bus.en) begin
                  r_state <= S_STOPPING;
                  r_busy  <= 1'b1;
               end
            end
            S_STOPPING: begin
               if (w_fire) r_mask_event <= r_pending;
               if (bus.en) begin
                  r_state   <= S_ON;
                  r_busy    <= 1'b0;
                  r_pending <= w_pending_upd;
               end else if (bus.carrier_zero) begin
                  r_state     <= S_OFF;
                  r_pwm_onoff <= PWM_OFF;
                  r_busy      <= 1'b0;
                  r_pending   <= '0;
               end else begin
                  r_pending <= w_pending_upd;
               end
            end
            default: begin
               r_state     <= S_OFF;
               r_pwm_onoff <= PWM_OFF;
               r_busy      <= 1'b0;
               r_pending   <= '0;
            end
         endcase
      end
   end

   assign bus.mask_event = r_mask_event;
   assign bus.pending    = r_pending;
   assign bus.pwm_onoff  = r_pwm_onoff;
   assign bus.busy       = r_busy;

`ifdef PWM_UPDATE_CNT_EN
   logic             w_cnt_inc;
   logic [CNT_W-1:0] r_update_count;

   // Counts edges that load a non-zero mask_event, including the arming all-ones pulse.
   assign w_cnt_inc = ((r_state == S_ARMING) && bus.en && bus.carrier_zero) ||
                      (((r_state == S_ON) || (r_state == S_STOPPING)) && w_fire);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_update_count <= '0;
      end else if (w_cnt_inc && (r_update_count != '1)) begin
         r_update_count <= r_update_count + CNT_W'(1);
      end
   end

   assign bus.update_count = r_update_count;
`else
   assign bus.update_count = '0;
`endif

endmodule

// File: tb/tb_pwm_shadow_update_ctrl.sv
// Randomized self-checking bench for pwm_shadow_update_ctrl against a cycle-level behavioural model.
module tb_pwm_shadow_update_ctrl;
   localparam int unsigned N_CH  = 4;
   localparam int unsigned CNT_W = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pwm_shadow_update_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();
   pwm_shadow_update_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk = 0;
   int n_err = 0;

   // Model: pwm running flag, transition-in-progress flag, pending set, last pulse, counter.
   bit       m_pwm;
   bit       m_busy;
   bit [3:0] m_pend;
   bit [3:0] m_mev;
   int       m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cnt_exp();
`ifdef PWM_UPDATE_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_pwm = 0; m_busy = 0; m_pend = '0; m_mev = '0; m_cnt = 0;
   endtask

   // One clock edge of the rules, evaluated on the inputs the bench is presenting.
   task automatic model_clock();
      bit       bnd;
      bit       fire;
      bit [3:0] nxt;
      case (bus.update_mode)
         2'd0:    bnd = bus.carrier_zero;
         2'd1:    bnd = bus.carrier_top;
         2'd2:    bnd = bus.carrier_zero | bus.carrier_top;
         default: bnd = 1'b1;
      endcase
      m_mev = '0;
      if (!m_pwm && !m_busy) begin
         m_pend = '0;
         if (bus.en) m_busy = 1;
      end else if (!m_pwm) begin
         if (!bus.en) m_busy = 0;
         else if (bus.carrier_zero) begin
            m_mev = 4'hF; m_pwm = 1; m_busy = 0;
         end
      end else begin
         fire = bnd && (m_pend != 0);
         if (fire) m_mev = m_pend;
         nxt = (fire ? 4'h0 : m_pend) | (bus.commit ? bus.commit_ch : 4'h0);
         if (!m_busy) begin
            m_pend = nxt;
            if (!bus.en) m_busy = 1;
         end else if (bus.en) begin
            m_busy = 0; m_pend = nxt;
         end else if (bus.carrier_zero) begin
            m_pwm = 0; m_busy = 0; m_pend = '0;
         end else begin
            m_pend = nxt;
         end
      end
      if (m_mev != 0 && m_cnt < 65535) m_cnt++;
   endtask

   task automatic check_outputs();
      chk("mask_event", bus.mask_event, m_mev);
      chk("pwm_onoff", bus.pwm_onoff, m_pwm);
      chk("pending", bus.pending, m_pend);
      chk("busy", bus.busy, m_busy);
      chk("update_count", bus.update_count, cnt_exp());
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      bus.en = 0; bus.carrier_zero = 0; bus.carrier_top = 0;
      bus.update_mode = 2'd0; bus.commit = 0; bus.commit_ch = '0;
      do_reset();

      // Arming: carrier_zero at cycle 10 gives all-ones pulse at cycle 11.
      bus.en = 1;
      step();
      repeat (8) step();
      bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
      chk("arm_mask", bus.mask_event, 4'b1111);
      chk("arm_pwm", bus.pwm_onoff, 1'b1);
      chk("arm_busy", bus.busy, 1'b0);
      step();
      chk("arm_one_shot", bus.mask_event, 4'b0000);

      // Mode 0: top ignored, update on zero.
      bus.update_mode = 2'd0;
      bus.commit = 1; bus.commit_ch = 4'b0101; step(); bus.commit = 0;
      chk("m0_pending", bus.pending, 4'b0101);
      bus.carrier_top = 1; step(); bus.carrier_top = 0;
      chk("m0_no_top", bus.mask_event, 4'b0000);
      bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
      chk("m0_zero", bus.mask_event, 4'b0101);
      chk("m0_clear", bus.pending, 4'b0000);

      // Mode 2: commit colliding with a firing boundary is deferred.
      bus.update_mode = 2'd2;
      bus.commit = 1; bus.commit_ch = 4'b1000; step();
      bus.commit_ch = 4'b0010; bus.carrier_zero = 1; step();
      bus.commit = 0; bus.carrier_zero = 0;
      chk("m2_first", bus.mask_event, 4'b1000);
      chk("m2_deferred", bus.pending, 4'b0010);
      step();
      bus.carrier_top = 1; step(); bus.carrier_top = 0;
      chk("m2_second", bus.mask_event, 4'b0010);

      // Stop: pending fires on the same edge pwm turns off; later commits ignored.
      bus.update_mode = 2'd0;
      bus.commit = 1; bus.commit_ch = 4'b0001; step(); bus.commit = 0;
      bus.en = 0; step();
      chk("stop_busy", bus.busy, 1'b1);
      chk("stop_pwm_held", bus.pwm_onoff, 1'b1);
      bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
      chk("stop_mask", bus.mask_event, 4'b0001);
      chk("stop_pwm_off", bus.pwm_onoff, 1'b0);
      bus.commit = 1; bus.commit_ch = 4'b1111; step(); bus.commit = 0;
      step();
      chk("off_ignores_commit", bus.pending, 4'b0000);

      // Asynchronous reset in STOPPING with everything pending.
      bus.en = 1; step();
      bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
      bus.commit = 1; bus.commit_ch = 4'b1111; step(); bus.commit = 0;
      bus.en = 0; step();
      chk("pre_rst_pending", bus.pending, 4'b1111);
      #3 reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("rst_pending", bus.pending, 4'b0000);
      chk("rst_busy", bus.busy, 1'b0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) begin
         bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
         chk("post_rst_quiet", bus.mask_event, 4'b0000);
         step();
      end

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
         if ($urandom_range(0, 63) == 0) bus.update_mode = 2'($urandom_range(0, 3));
         bus.carrier_zero = ($urandom_range(0, 7) == 0);
         bus.carrier_top  = ($urandom_range(0, 7) == 0);
         bus.commit       = ($urandom_range(0, 3) == 0);
         bus.commit_ch    = 4'($urandom_range(0, 15));
         step();
      end
      bus.carrier_zero = 0; bus.carrier_top = 0; bus.commit = 0;

      // Mode 3 latency, then counter saturation when the counter is built in.
      do_reset();
      bus.en = 1; step();
      bus.carrier_zero = 1; step(); bus.carrier_zero = 0;
      bus.update_mode = 2'd3;
      bus.commit = 1; bus.commit_ch = 4'b0100; step(); bus.commit = 0;
      chk("m3_t1_none", bus.mask_event, 4'b0000);
      step();
      chk("m3_t2_fire", bus.mask_event, 4'b0100);
`ifdef PWM_UPDATE_CNT_EN
      bus.commit = 1; bus.commit_ch = 4'b0001;
      for (int i = 0; i < 65540; i++) step();
      bus.commit = 0;
      step();
      chk("cnt_saturated", bus.update_count, 32'h0000_FFFF);
`else
      chk("cnt_tied_zero", bus.update_count, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pwm_shadow_update_ctrl.md
Name: pwm_shadow_update_ctrl

Overview:
Sequences shadow-register updates for a bank of PWM channels. Software commits new duty/period values, and this block decides when each channel's 16-bit register mask becomes transparent. It generates per-channel single-cycle mask_event pulses aligned to carrier-counter boundaries and drives the PWM on/off state shared by all channels. It sits between the CPU register interface and the per-channel mask registers.

Parameters:
N_CH, 4, number of PWM channels (one mask_event bit each)
CNT_W, 16, width of update_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
en  input  1  level request: 1 = run PWM, 0 = stop PWM
carrier_zero  input  1  single-cycle pulse when carrier counter equals 0
carrier_top  input  1  single-cycle pulse when carrier counter equals period
update_mode  input  2  0 = update at zero, 1 = at top, 2 = at zero or top, 3 = immediate
commit  input  1  single-cycle pulse requesting an update for channels in commit_ch
commit_ch  input  N_CH  channel select for commit
mask_event  output  N_CH  single-cycle per-channel mask transparency pulse
pwm_onoff  output  1  _pwm_onoff: PWM_OFF / PWM_ON
pending  output  N_CH  committed channels not yet updated
busy  output  1  high in ARMING or STOPPING
update_count  output  CNT_W  number of update boundaries that fired at least one channel

Behaviour:
- Reset (reset=0, asynchronous):
  - state = OFF, pwm_onoff = PWM_OFF.
  - mask_event, pending, busy and update_count all 0.
  - Reset asserted mid-operation aborts immediately; pending updates are lost.
- Boundary event bnd, evaluated combinationally:
  - mode 0: carrier_zero
  - mode 1: carrier_top
  - mode 2: carrier_zero OR carrier_top
  - mode 3: 1 every cycle
- FSM states: OFF, ARMING, ON, STOPPING.
- OFF:
  - pwm_onoff = PWM_OFF; downstream masks are transparent, so no mask_event is needed.
  - commit is ignored and pending is held at 0.
  - en=1 moves to ARMING.
- ARMING:
  - busy = 1; waits for carrier_zero regardless of update_mode.
  - On carrier_zero: mask_event = all ones for one cycle, pwm_onoff = PWM_ON from the same edge, next state ON.
  - en=0 while in ARMING returns to OFF with no mask_event.
- ON:
  - commit ORs commit_ch into pending, registered with 1-cycle latency.
  - On a cycle with bnd=1 and pending != 0: mask_event = pending for one cycle, and pending clears.
  - If commit arrives in the same cycle as a firing bnd, its channels are NOT included. They stay set in pending and fire at the next bnd, so a partial write is never applied.
  - Mode 3: a commit at cycle t produces mask_event at t+2.
  - en=0 moves to STOPPING.
- STOPPING:
  - busy = 1; pwm_onoff stays PWM_ON.
  - Pending channels still fire at bnd.
  - On carrier_zero: pwm_onoff = PWM_OFF, pending cleared, next state OFF.
  - If carrier_zero coincides with bnd and pending != 0, mask_event fires first in that cycle, then OFF.
  - en=1 while in STOPPING returns to ON.
- update_count:
  - Increments on every cycle where mask_event != 0, including the ARMING all-ones pulse.
  - Saturates at all ones (no wrap-around).
- Simultaneous carrier_zero and carrier_top (period = 0): treated as a single boundary, one pulse.
- mask_event is registered (glitch-free) and is never asserted for two consecutive cycles for the same channel, except in mode 3.

Optional Feature:
PWM_UPDATE_CNT_EN:
- Defined: update_count is implemented as specified above.
- Undefined: the counter logic is removed and update_count is tied to 0.

Test Plan:
- Reset then en=1, carrier_zero pulse at cycle 10 -> mask_event=4'b1111 at cycle 11, pwm_onoff=PWM_ON, busy low from cycle 11.
- ON, mode 0, commit with commit_ch=4'b0101, carrier_top then carrier_zero -> no pulse at top; mask_event=4'b0101 one cycle after zero; pending returns to 0.
- ON, mode 2, commit with 4'b0010 in the same cycle as a firing carrier_zero while pending=4'b1000 -> mask_event=4'b1000 now, 4'b0010 at the next carrier_top.
- ON, en=0, pending=4'b0001, carrier_zero -> mask_event=4'b0001 and pwm_onoff=PWM_OFF on the same edge; state OFF; commits ignored afterwards.
- reset driven low mid-STOPPING with pending=4'b1111 -> all outputs 0 asynchronously; no mask_event after release.
- PWM_UPDATE_CNT_EN defined, 0xFFFF+3 firing boundaries in mode 3 -> update_count saturates at 0xFFFF; undefined -> always 0.
